// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: states, ALUOp codes,
// opcode/funct constants, datapath select codes and the decoded control word.
package mips_ctrl_pkg;

    localparam int unsigned ST_W   = 3;
    localparam logic [4:0]  RA_REG = 5'd31;

    typedef enum logic [ST_W-1:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    // Must stay identical to the codes decoded by the ALU control block.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_FUNCT = 4'd2,
        ALU_AND   = 4'd3,
        ALU_LU    = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_ADDU  = 4'd6,
        ALU_SLTU  = 4'd7
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [1:0] MTR_ALUOUT = 2'd0;
    localparam logic [1:0] MTR_MDR    = 2'd1;
    localparam logic [1:0] MTR_PC     = 2'd2;

    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_RS     = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        aluop_t     alu_op;
        logic       ext_op;
        logic       lu_op;
    } ctrl_t;

    function automatic logic is_ialu_op(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: is_ialu_op = 1'b1;
            default:                                              is_ialu_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_LW, OP_SW: is_legal_op = 1'b1;
            default:                                       is_legal_op = is_ialu_op(op);
        endcase
    endfunction

    function automatic logic is_defined_funct(input logic [5:0] fn);
        case (fn)
            FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_JALR,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU:  is_defined_funct = 1'b1;
            default:          is_defined_funct = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/main_ctrl_decode.sv
// Combinational decode of (state, opcode, funct) into the datapath control word
// and the next state. Optional IllegalInst output under CTRL_ILLEGAL_TRAP_EN.
module main_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic       o_illegal,
`endif
    output state_t     o_next_state
);

    logic w_illegal;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign w_illegal = !is_legal_op(i_opcode) ||
                       ((i_opcode == OP_RTYPE) && !is_defined_funct(i_funct));
    assign o_illegal = (i_state == ST_ID) && w_illegal;
`else
    assign w_illegal = !is_legal_op(i_opcode);
`endif

    always_comb begin
        o_ctrl       = '0;
        o_next_state = ST_IF;
        case (i_state)
            ST_IF: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.pc_write  = 1'b1;
                o_next_state     = ST_ID;
            end
            ST_ID: begin
                // Branch target is computed speculatively into ALUOut here.
                o_ctrl.alu_src_b = SRCB_IMM_SH;
                o_ctrl.ext_op    = 1'b1;
                o_next_state     = ST_EX;
                if (w_illegal) begin
                    o_next_state = ST_IF;
                end else if (i_opcode == OP_J || i_opcode == OP_JAL) begin
                    o_ctrl.pc_write  = 1'b1;
                    o_ctrl.pc_source = PCS_JUMP;
                    o_next_state     = ST_IF;
                    if (i_opcode == OP_JAL) begin
                        o_ctrl.reg_write  = 1'b1;
                        o_ctrl.reg_dst    = RDST_RA;
                        o_ctrl.mem_to_reg = MTR_PC;
                    end
                end else if (i_opcode == OP_RTYPE &&
                             (i_funct == FN_JR || i_funct == FN_JALR)) begin
                    o_ctrl.pc_write  = 1'b1;
                    o_ctrl.pc_source = PCS_RS;
                    o_next_state     = ST_IF;
                    if (i_funct == FN_JALR) begin
                        o_ctrl.reg_write  = 1'b1;
                        o_ctrl.reg_dst    = RDST_RD;
                        o_ctrl.mem_to_reg = MTR_PC;
                    end
                end
            end
            ST_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                case (i_opcode)
                    OP_RTYPE: begin
                        o_ctrl.alu_src_b = SRCB_RT;
                        o_ctrl.alu_op    = ALU_FUNCT;
                        o_next_state     = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        o_ctrl.alu_src_b = SRCB_IMM;
                        o_ctrl.ext_op    = 1'b1;
                        o_ctrl.alu_op    = ALU_ADD;
                        o_next_state     = ST_MEM;
                    end
                    OP_BEQ: begin
                        o_ctrl.alu_src_b     = SRCB_RT;
                        o_ctrl.alu_op        = ALU_SUB;
                        o_ctrl.pc_write_cond = 1'b1;
                        o_ctrl.pc_source     = PCS_ALUOUT;
                    end
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: begin
                        o_ctrl.alu_src_b = SRCB_IMM;
                        o_ctrl.ext_op    = (i_opcode != OP_ANDI);
                        o_ctrl.lu_op     = (i_opcode == OP_LUI);
                        o_next_state     = ST_WB;
                        case (i_opcode)
                            OP_ADDIU: o_ctrl.alu_op = ALU_ADDU;
                            OP_SLTI:  o_ctrl.alu_op = ALU_SLT;
                            OP_SLTIU: o_ctrl.alu_op = ALU_SLTU;
                            OP_ANDI:  o_ctrl.alu_op = ALU_AND;
                            OP_LUI:   o_ctrl.alu_op = ALU_LU;
                            default:  o_ctrl.alu_op = ALU_ADD;
                        endcase
                    end
                    default: o_next_state = ST_IF;
                endcase
            end
            ST_MEM: begin
                o_ctrl.iord = 1'b1;
                if (i_opcode == OP_LW) begin
                    o_ctrl.mem_read = 1'b1;
                    o_next_state    = ST_WB;
                end else if (i_opcode == OP_SW) begin
                    o_ctrl.mem_write = 1'b1;
                end
            end
            ST_WB: begin
                if (i_opcode == OP_LW) begin
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.mem_to_reg = MTR_MDR;
                    o_ctrl.reg_dst    = RDST_RT;
                end else if (i_opcode == OP_RTYPE) begin
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.mem_to_reg = MTR_ALUOUT;
                    o_ctrl.reg_dst    = RDST_RD;
                end else if (is_ialu_op(i_opcode)) begin
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.mem_to_reg = MTR_ALUOUT;
                    o_ctrl.reg_dst    = RDST_RT;
                end
            end
            default: o_next_state = ST_IF;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main controller FSM of the 5-state multi-cycle MIPS CPU: state register plus reset
// gating of the decoded control word. CTRL_ILLEGAL_TRAP_EN adds the IllegalInst output.
module multicycle_main_control
    import mips_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      OpCode,
    input  logic [5:0]      Funct,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic [1:0]      MemtoReg,
    output logic [1:0]      RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      PCSource,
    output logic [3:0]      ALUOp,
    output logic            ExtOp,
    output logic            LuOp,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic            IllegalInst,
`endif
    output logic [ST_W-1:0] State
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    ctrl_t  w_ctrl_out;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic   w_illegal;
`endif

    main_ctrl_decode u_decode (
        .i_state      (r_state),
        .i_opcode     (OpCode),
        .i_funct      (Funct),
        .o_ctrl       (w_ctrl),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .o_illegal    (w_illegal),
`endif
        .o_next_state (w_next_state)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // State already reads IF during reset; the gate keeps IF strobes from firing early.
    always_comb begin
        w_ctrl_out = reset ? w_ctrl : '0;
    end

    assign PCWrite     = w_ctrl_out.pc_write;
    assign PCWriteCond = w_ctrl_out.pc_write_cond;
    assign IorD        = w_ctrl_out.iord;
    assign MemRead     = w_ctrl_out.mem_read;
    assign MemWrite    = w_ctrl_out.mem_write;
    assign IRWrite     = w_ctrl_out.ir_write;
    assign MemtoReg    = w_ctrl_out.mem_to_reg;
    assign RegDst      = w_ctrl_out.reg_dst;
    assign RegWrite    = w_ctrl_out.reg_write;
    assign ALUSrcA     = w_ctrl_out.alu_src_a;
    assign ALUSrcB     = w_ctrl_out.alu_src_b;
    assign PCSource    = w_ctrl_out.pc_source;
    assign ALUOp       = w_ctrl_out.alu_op;
    assign ExtOp       = w_ctrl_out.ext_op;
    assign LuOp        = w_ctrl_out.lu_op;
    assign State       = r_state;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign IllegalInst = reset & w_illegal;
`endif

endmodule
